// File: rtl/coreuart_pkg.sv
// Shared types and constants for the CoreUART transmit path.
// Holds the engine state enum, timing defaults, data-bit terminals and a parity helper.
package coreuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_e;

    localparam int OVERSAMPLE_DEF   = 16;
    localparam int READ_LATENCY_DEF = 2;
    // Wide enough for any legal oversample ratio (8..16).
    localparam int TICK_W           = 4;

    localparam logic [2:0] BIT_LAST_7 = 3'd6;
    localparam logic [2:0] BIT_LAST_8 = 3'd7;

    function automatic logic [2:0] bit_last(input logic bit8);
        return bit8 ? BIT_LAST_8 : BIT_LAST_7;
    endfunction

    // In 7-bit mode the unsent bit 7 must not contribute to parity.
    function automatic logic parity_bit(input logic [7:0] data, input logic bit8, input logic odd);
        logic [7:0] sent;
        sent = bit8 ? data : {1'b0, data[6:0]};
        return (^sent) ^ odd;
    endfunction

endpackage

// File: rtl/coreuart_bit_timer.sv
// Counts BAUD_EN ticks within one serial bit and strobes bit_end on the last tick.
// clear has priority over tick so a freshly started bit always begins at count 0.
module coreuart_bit_timer
    import coreuart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic bit_end
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_cnt_q;
        if (clear) begin
            tick_cnt_d = '0;
        end else if (tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end
    end

    assign bit_end = tick && !clear && (tick_cnt_q == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

endmodule

// File: rtl/coreuart_tx_engine.sv
// CoreUART transmit serializer: pops the TX FIFO, frames start/data/parity/stop, drives TX.
// Build option COREUART_TX_BREAK_EN adds SEND_BREAK, which forces the line low and blocks FIFO reads in IDLE.
module coreuart_tx_engine
    import coreuart_pkg::*;
#(
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int OVERSAMPLE   = OVERSAMPLE_DEF
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       BAUD_EN,
    input  logic       BIT8,
    input  logic       PARITY_EN,
    input  logic       ODD_N_EVEN,
    input  logic       FIFO_EMPTY,
    input  logic [7:0] FIFO_DATA,
    output logic       FIFO_RD_N,
    output logic       TX,
    output logic       TX_BUSY,
    output logic       TX_DONE,
`ifdef COREUART_TX_BREAK_EN
    input  logic       SEND_BREAK,
`endif
    output state_e     dbg_state
);

    localparam logic [1:0] FETCH_LAST = 2'(READ_LATENCY);

    state_e     state_q, state_d;
    logic [1:0] fetch_cnt_q, fetch_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] data_q, data_d;
    logic       bit8_q, bit8_d;
    logic       par_en_q, par_en_d;
    logic       odd_q, odd_d;
    logic       tx_fsm_q, tx_fsm_d;
    logic       tx_q, tx_d;
    logic       rd_n_q, rd_n_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       break_req;
    logic       timer_clear;
    logic       bit_end;
    logic [2:0] next_bit;

`ifdef COREUART_TX_BREAK_EN
    assign break_req = SEND_BREAK;
`else
    assign break_req = 1'b0;
`endif

    // Bit timing only runs once a byte is captured; START begins at tick count 0.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);
    assign next_bit    = bit_cnt_q + 3'd1;

    coreuart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .clear   (timer_clear),
        .tick    (BAUD_EN),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        bit8_d      = bit8_q;
        par_en_d    = par_en_q;
        odd_d       = odd_q;
        tx_fsm_d    = tx_fsm_q;
        busy_d      = busy_q;
        rd_n_d      = 1'b1;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!FIFO_EMPTY && !break_req) begin
                    rd_n_d      = 1'b0;
                    busy_d      = 1'b1;
                    fetch_cnt_d = '0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (fetch_cnt_q == FETCH_LAST) begin
                    data_d   = FIFO_DATA;
                    bit8_d   = BIT8;
                    par_en_d = PARITY_EN;
                    odd_d    = ODD_N_EVEN;
                    tx_fsm_d = 1'b0;
                    state_d  = ST_START;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 2'd1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    tx_fsm_d  = data_q[0];
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == bit_last(bit8_q)) begin
                        if (par_en_q) begin
                            tx_fsm_d = parity_bit(data_q, bit8_q, odd_q);
                            state_d  = ST_PARITY;
                        end else begin
                            tx_fsm_d = 1'b1;
                            state_d  = ST_STOP;
                        end
                    end else begin
                        bit_cnt_d = next_bit;
                        tx_fsm_d  = data_q[next_bit];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    tx_fsm_d = 1'b1;
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_fsm_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        // Break only masks the line; the frame underneath keeps its timing.
        tx_d = tx_fsm_d & ~break_req;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            fetch_cnt_q <= '0;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            bit8_q      <= 1'b0;
            par_en_q    <= 1'b0;
            odd_q       <= 1'b0;
            tx_fsm_q    <= 1'b1;
            tx_q        <= 1'b1;
            rd_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            bit8_q      <= bit8_d;
            par_en_q    <= par_en_d;
            odd_q       <= odd_d;
            tx_fsm_q    <= tx_fsm_d;
            tx_q        <= tx_d;
            rd_n_q      <= rd_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign TX        = tx_q;
    assign FIFO_RD_N = rd_n_q;
    assign TX_BUSY   = busy_q;
    assign TX_DONE   = done_q;
    assign dbg_state = state_q;

endmodule
